// File: rtl/latch_reader.sv
// Latched-event reader: synchronizes external SR-latch outputs, clears each latch
// after capture and queues {channel mask, timestamp} tags in a fall-through FIFO.

module latch_reader_ch #(
  parameter int CLR_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic qs,
  output logic mask,
  output logic latch_r
);
  typedef enum logic [1:0] {IDLE, CLEAR, WAIT_LOW} state_e;
  localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask    = 1'b0;
    latch_r = 1'b0;
    unique case (state_q)
      IDLE: if (qs) begin
        mask    = 1'b1;
        state_d = CLEAR;
        cnt_d   = '0;
      end
      CLEAR: begin
        latch_r = 1'b1;
        if (cnt_q == CW'(CLR_CYC - 1)) state_d = WAIT_LOW;
        else                           cnt_d   = cnt_q + CW'(1);
      end
      // Stay out of IDLE until the latch is seen low, so one event gives one tag.
      WAIT_LOW: if (!qs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

module latch_reader #(
  parameter int NCH     = 4,
  parameter int TS_W    = 32,
  parameter int DEPTH   = 16,
  parameter int CLR_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          latch_q,
  output logic [NCH-1:0]          latch_r,
  output logic [NCH+TS_W-1:0]     tag_data,
  output logic                    tag_valid,
  input  logic                    tag_ready,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow,
  input  logic                    ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = NCH + TS_W;

  logic [NCH-1:0]  s1_q, s1_d, s2_q, s2_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [NCH-1:0]  mask;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic            push, pop, full, wr_en, drop;
  logic [TW-1:0]   wr_data;
  logic [TW-1:0]   mem_q [DEPTH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    latch_reader_ch #(.CLR_CYC(CLR_CYC)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .qs      (s2_q[g]),
      .mask    (mask[g]),
      .latch_r (latch_r[g])
    );
  end

  always_comb begin
    s1_d      = latch_q;
    s2_d      = s1_q;
    ts_d      = ts_q + TS_W'(1);
    push      = |mask;
    tag_valid = (level_q != '0);
    pop       = tag_valid & tag_ready;
    full      = (level_q == LW'(DEPTH));
    // When full, a pop in the same cycle frees the slot being written.
    wr_en     = push & (~full | pop);
    drop      = push & full & ~pop;
    wr_data   = {mask, ts_q};
    wr_ptr_d  = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q;
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    overflow_d = drop | (overflow_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: contents are only observed behind tag_valid.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= wr_data;
  end

  assign tag_data   = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
endmodule
